// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//
// Word-addressed RAM slave for the cache's memory-side req/gnt/rvalid port.
// Grant and response latency are set by parameters so that line fills and
// write-throughs can be run against realistic wait states. At most one
// transaction is outstanding; a new request can be granted in the same cycle
// that the previous response is presented.
//
// Parameters
//   WORD_COUNT    RAM depth in 32-bit words (power of two)
//   BASE_ADDR     byte address of word 0, aligned to 4*WORD_COUNT
//   GNT_DELAY     cycles req_i must be held before gnt_o (0..15)
//   RVALID_DELAY  cycles from the acceptance edge to rvalid_o (1..15)
//
// Ports
//   clk       clock
//   reset     asynchronous, active-high reset
//   req_i     request, held until granted
//   addr_i    byte address, bits [1:0] ignored
//   we_i      1 = write, 0 = read
//   be_i      byte enables for writes, bit n covers wdata_i[8n+7:8n]
//   wdata_i   write data
//   gnt_o     grant, combinational from req_i and state
//   rvalid_o  one-cycle response pulse, registered
//   rdata_o   read data (0 for writes, 32'hDEAD_BEEF when out of range)
//   err_o     address out of range, qualified by rvalid_o
//
// Optional feature
//   MEM_RESP_RANDOM_STALL_EN  when defined, an 8-bit LFSR adds 0..3 random
//                             cycles to the grant delay of each request.

module cache_mem_responder #(
  parameter int unsigned WORD_COUNT   = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RVALID_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW          = $clog2(WORD_COUNT);
  localparam logic [4:0]  LP_GNT_DLY  = 5'(GNT_DELAY);
  localparam logic [4:0]  LP_LAT_LAST = 5'(RVALID_DELAY - 1);
  localparam logic [31:0] LP_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StLat,
    StResp
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [4:0]  r_gnt_cnt;
  logic [4:0]  w_gnt_cnt_d;
  logic [4:0]  r_lat_cnt;
  logic [4:0]  w_lat_cnt_d;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [WORD_COUNT];

  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_eval;
  logic [4:0]    w_eval_dly;
  logic [4:0]    w_wait_tgt;
  logic [1:0]    w_unused_addr;

  // Base is aligned to the RAM size, so the range check reduces to matching
  // the address bits above the word index.
  assign w_in_range    = (addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_idx         = addr_i[AW+1:2];
  assign w_unused_addr = addr_i[1:0];

  // IDLE and RESP both look at a fresh request.
  assign w_eval = req_i && ((r_state == StIdle) || (r_state == StResp));

`ifdef MEM_RESP_RANDOM_STALL_EN
  logic [7:0] r_lfsr;
  logic [4:0] r_gnt_tgt;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_eval_dly = LP_GNT_DLY + {3'b000, r_lfsr[1:0]};

  // The stall is sampled once per request, so the wait target must be held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt_tgt <= '0;
    end else if (w_eval && (w_eval_dly != 5'd0)) begin
      r_gnt_tgt <= w_eval_dly;
    end
  end

  assign w_wait_tgt = r_gnt_tgt;
`else
  assign w_eval_dly = LP_GNT_DLY;
  assign w_wait_tgt = LP_GNT_DLY;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_gnt_cnt <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_gnt_cnt <= w_gnt_cnt_d;
      r_lat_cnt <= w_lat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d   = r_state;
    w_gnt_cnt_d = r_gnt_cnt;
    w_lat_cnt_d = r_lat_cnt;

    case (r_state)
      StIdle, StResp: begin
        w_state_d   = StIdle;
        w_gnt_cnt_d = '0;
        w_lat_cnt_d = '0;
        if (req_i && (w_eval_dly != 5'd0)) begin
          // This cycle already counts as the first one with req_i held.
          w_state_d   = StWaitGnt;
          w_gnt_cnt_d = 5'd1;
        end
      end
      StWaitGnt: begin
        if (!req_i) begin
          w_state_d   = StIdle;
          w_gnt_cnt_d = '0;
        end else if (r_gnt_cnt != w_wait_tgt) begin
          w_gnt_cnt_d = r_gnt_cnt + 5'd1;
        end
      end
      StLat: begin
        if (r_lat_cnt == LP_LAT_LAST) begin
          w_state_d   = StResp;
          w_lat_cnt_d = '0;
        end else begin
          w_lat_cnt_d = r_lat_cnt + 5'd1;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_gnt_cnt_d = '0;
        w_lat_cnt_d = '0;
      end
    endcase

    // Acceptance overrides whatever the state decided above.
    if (w_accept) begin
      w_gnt_cnt_d = '0;
      if (RVALID_DELAY <= 1) begin
        w_state_d   = StResp;
        w_lat_cnt_d = '0;
      end else begin
        w_state_d   = StLat;
        w_lat_cnt_d = 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_o = 1'b0;
    case (r_state)
      StIdle, StResp: gnt_o = req_i && (w_eval_dly == 5'd0);
      StWaitGnt:      gnt_o = req_i && (r_gnt_cnt == w_wait_tgt);
      default:        gnt_o = 1'b0;
    endcase
    // Keeps the grant low while reset is held, which also blocks RAM writes.
    if (reset) begin
      gnt_o = 1'b0;
    end
  end

  assign w_accept = gnt_o;

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= (w_state_d == StResp);
      if (w_accept) begin
        if (!w_in_range) begin
          r_rdata <= LP_ERR_DATA;
          r_err   <= 1'b1;
        end else if (we_i) begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end else begin
          r_rdata <= r_mem[w_idx];
          r_err   <= 1'b0;
        end
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  // ---------------------------------------------------------------------------
  // RAM, not reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept && w_in_range && we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) begin
          r_mem[w_idx][8*l +: 8] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder. Three instances share clock and reset:
//   u0  defaults (GNT_DELAY=0, RVALID_DELAY=1)
//   u1  GNT_DELAY=3, RVALID_DELAY=2
//   u2  GNT_DELAY=0, RVALID_DELAY=4
// Expects MEM_RESP_RANDOM_STALL_EN to be undefined.

module tb_cache_mem_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk;
  logic        reset;
  logic        req    [3];
  logic [31:0] addr   [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int gd [3] = '{0, 3, 0};
  int rd [3] = '{1, 2, 4};

  int checks   = 0;
  int failures = 0;

  cache_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(1)) u0 (
    .clk(clk), .reset(reset), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );
  cache_mem_responder #(.GNT_DELAY(3), .RVALID_DELAY(2)) u1 (
    .clk(clk), .reset(reset), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );
  cache_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(4)) u2 (
    .clk(clk), .reset(reset), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tv[$];

  // Reference RAM for u1's randomized phase.
  bit [31:0] mm [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // One full transaction with latency checks; req dropped after the grant.
  task automatic do_txn(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] r, output logic e);
    int n;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    settle();
    n = 0;
    while (gnt[i] !== 1'b1 && n < 20) begin
      next_cyc(); settle(); n++;
    end
    chk($sformatf("gnt_latency_u%0d", i), 32'(n), 32'(gd[i]));
    next_cyc();
    req[i] = 1'b0;
    settle();
    n = 1;
    while (rvalid[i] !== 1'b1 && n < 20) begin
      next_cyc(); settle(); n++;
    end
    chk($sformatf("rvalid_latency_u%0d", i), 32'(n), 32'(rd[i]));
    r = rdata[i];
    e = err[i];
    next_cyc();
  endtask

  // Model-side response for an access to u1, applied at its grant.
  task automatic model_access(input bit w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, output logic [31:0] r, output logic e);
    int ix;
    if (a < BASE || a >= BASE + 32'h1000) begin
      r = 32'hDEAD_BEEF;
      e = 1'b1;
    end else begin
      ix = int'((a - BASE) >> 2);
      e  = 1'b0;
      if (w) begin
        for (int l = 0; l < 4; l++) if (b[l]) mm[ix][8*l +: 8] = d[8*l +: 8];
        r = 32'h0;
      end else begin
        r = mm[ix];
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end

    // Reset state
    next_cyc(); next_cyc(); settle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_gnt_u%0d", i),    32'(gnt[i]),    32'h0);
      chk($sformatf("reset_rvalid_u%0d", i), 32'(rvalid[i]), 32'h0);
      chk($sformatf("reset_rdata_u%0d", i),  rdata[i],       32'h0);
      chk($sformatf("reset_err_u%0d", i),    32'(err[i]),    32'h0);
    end
    reset = 1'b0;
    next_cyc();

    // Table-driven single transactions on u0
    tv.push_back('{1'b1, 32'h0010_0010, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0010, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0013, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0});
    tv.push_back('{1'b1, 32'h0010_0020, 4'hF, 32'h1111_1111, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b1, 32'h0010_0020, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0020, 4'h0, 32'h0,         32'h11BB_11DD, 1'b0});
    tv.push_back('{1'b1, 32'h0010_0020, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0020, 4'h0, 32'h0,         32'h11BB_11DD, 1'b0});
    tv.push_back('{1'b1, 32'h0010_0000, 4'hF, 32'hA0A0_A0A0, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b1, 32'h0010_0FFC, 4'hF, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0});
    tv.push_back('{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1});
    tv.push_back('{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1});
    tv.push_back('{1'b0, 32'h0010_1000, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1});
    tv.push_back('{1'b1, 32'h0010_1000, 4'hF, 32'h8765_4321, 32'hDEAD_BEEF, 1'b1});
    tv.push_back('{1'b1, 32'h000F_FFFC, 4'hF, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1'b1});
    tv.push_back('{1'b1, 32'h0010_0FFC, 4'h0, 32'h0,         32'h0000_0000, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0000, 4'h0, 32'h0,         32'hA0A0_A0A0, 1'b0});
    tv.push_back('{1'b0, 32'h0010_0FFC, 4'h0, 32'h0,         32'h5A5A_5A5A, 1'b0});
    foreach (tv[k]) begin
      do_txn(0, tv[k].w, tv[k].a, tv[k].b, tv[k].d, r, e);
      chk($sformatf("tv%0d_rdata", k), r, tv[k].exp_rdata);
      chk($sformatf("tv%0d_err", k), 32'(e), 32'(tv[k].exp_err));
    end

    // Back-to-back on u0: four writes, then four reads of the same words
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 6; k++) begin
        req[0]   = (k < 4);
        we[0]    = (ph == 0);
        be[0]    = 4'hF;
        addr[0]  = BASE + 32'h40 + 32'(4 * (k < 4 ? k : 3));
        wdata[0] = 32'h0B0B_0000 + 32'(k);
        settle();
        chk($sformatf("b2b_p%0d_gnt%0d", ph, k), 32'(gnt[0]), 32'(k < 4));
        chk($sformatf("b2b_p%0d_rvalid%0d", ph, k), 32'(rvalid[0]), 32'(k >= 1 && k <= 4));
        if (k >= 1 && k <= 4) begin
          chk($sformatf("b2b_p%0d_rdata%0d", ph, k), rdata[0],
              (ph == 0) ? 32'h0 : 32'h0B0B_0000 + 32'(k - 1));
          chk($sformatf("b2b_p%0d_err%0d", ph, k), 32'(err[0]), 32'h0);
        end
        next_cyc();
      end
    end

    // Line-fill burst on u1 with req held throughout
    for (int j = 0; j < 4; j++) do_txn(1, 1'b1, BASE + 32'h80 + 32'(4 * j), 4'hF,
                                       32'hB000_0000 + 32'(j), r, e);
    begin
      int g = 0;
      int n = 0;
      for (int c = 0; c < 23; c++) begin
        req[1]  = (g < 4);
        we[1]   = 1'b0;
        addr[1] = BASE + 32'h80 + 32'(4 * (g < 4 ? g : 3));
        settle();
        chk($sformatf("burst_gnt_c%0d", c), 32'(gnt[1]),
            32'(c >= 3 && c <= 18 && (c - 3) % 5 == 0));
        chk($sformatf("burst_rvalid_c%0d", c), 32'(rvalid[1]),
            32'(c >= 5 && c <= 20 && (c - 5) % 5 == 0));
        if (gnt[1] === 1'b1) g++;
        if (rvalid[1] === 1'b1) begin
          chk($sformatf("burst_rdata%0d", n), rdata[1], 32'hB000_0000 + 32'(n));
          n++;
        end
        next_cyc();
      end
      chk("burst_responses", 32'(n), 32'd4);
    end

    // Reset abort on u2
    do_txn(2, 1'b1, BASE + 32'h200, 4'hF, 32'h600D_F00D, r, e);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'h200;
    settle();
    chk("abort_gnt", 32'(gnt[2]), 32'h1);
    next_cyc();
    req[2] = 1'b0;
    next_cyc();
    reset = 1'b1;
    settle();
    chk("abort_rst_gnt",    32'(gnt[2]),    32'h0);
    chk("abort_rst_rvalid", 32'(rvalid[2]), 32'h0);
    chk("abort_rst_rdata",  rdata[2],       32'h0);
    chk("abort_rst_err",    32'(err[2]),    32'h0);
    next_cyc();
    reset = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 8; c++) begin
        settle();
        if (rvalid[2] === 1'b1) pulses++;
        next_cyc();
      end
      chk("abort_no_rvalid", 32'(pulses), 32'h0);
    end
    do_txn(2, 1'b0, BASE + 32'h200, 4'h0, 32'h0, r, e);
    chk("abort_after_rdata", r, 32'h600D_F00D);
    chk("abort_after_err", 32'(e), 32'h0);

    // Randomized traffic on u1 against a transaction-level model
    for (int j = 0; j < 8; j++) begin
      logic [31:0] d;
      d = $urandom;
      do_txn(1, 1'b1, BASE + 32'h100 + 32'(4 * j), 4'hF, d, r, e);
      mm[64 + j] = d;
    end
    begin
      bit          pend = 1'b0;
      bit          busy = 1'b0;
      int          due  = -1;
      int          held = 0;
      bit          elig, exp_gnt, exp_rv;
      logic [31:0] exp_d;
      logic        exp_e;
      int          k;
      for (int c = 0; c < 600; c++) begin
        if (pend) begin
          if ($urandom_range(0, 99) < 3) req[1] = 1'b0;
        end else begin
          req[1]   = ($urandom_range(0, 99) < 60);
          we[1]    = $urandom_range(0, 1) == 1;
          be[1]    = 4'($urandom_range(0, 15));
          wdata[1] = $urandom;
          k        = $urandom_range(0, 9);
          if (k < 8)       addr[1] = BASE + 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3));
          else if (k == 8) addr[1] = $urandom_range(0, 1) == 1 ? BASE - 32'd4
                                                               : ($urandom & 32'h000F_FFFF);
          else             addr[1] = BASE + 32'h1000 + 32'($urandom_range(0, 255) << 2);
        end
        settle();
        elig    = !busy || (due == c);
        exp_rv  = busy && (due == c);
        exp_gnt = elig && req[1] && (held == gd[1]);
        chk($sformatf("rand_gnt_c%0d", c), 32'(gnt[1]), 32'(exp_gnt));
        chk($sformatf("rand_rvalid_c%0d", c), 32'(rvalid[1]), 32'(exp_rv));
        if (exp_rv) begin
          chk($sformatf("rand_rdata_c%0d", c), rdata[1], exp_d);
          chk($sformatf("rand_err_c%0d", c), 32'(err[1]), 32'(exp_e));
          busy = 1'b0;
        end
        if (exp_gnt) begin
          model_access(we[1], addr[1], be[1], wdata[1], exp_d, exp_e);
          busy = 1'b1;
          due  = c + rd[1];
          held = 0;
        end else if (elig && req[1]) begin
          held++;
        end else begin
          held = 0;
        end
        pend = req[1] && (gnt[1] !== 1'b1);
        next_cyc();
      end
      req[1] = 1'b0;
      for (int c = 0; c < 4; c++) next_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Word-addressed memory slave answering the req/gnt/rvalid protocol issued by the cache's memory-side port. Backs a local RAM of `WORD_COUNT` 32-bit words with programmable grant and response latency, so cache line fills and write-throughs can be exercised under realistic wait states. Sits between the cache's memory port and the system bus, or standalone in cache benches. Supports one outstanding transaction, with back-to-back acceptance during the response cycle.

## Interface
- `WORD_COUNT`, 1024: RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0010_0000: byte address of word 0; aligned to `4*WORD_COUNT`.
- `GNT_DELAY`, 0: cycles `req_i` must be held before `gnt_o`; range 0..15.
- `RVALID_DELAY`, 1: cycles from the acceptance edge to `rvalid_o`; range 1..15.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  request; held until granted.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables for writes; bit n covers wdata[8n+7:8n].
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  grant; combinational from `req_i` and state.
- `rvalid_o`  out  1  response valid; one-cycle pulse, registered.
- `rdata_o`  out  32  read data; valid while `rvalid_o`=1.
- `err_o`  out  1  address out of range; valid while `rvalid_o`=1.

## Operation
- Acceptance: `req_i && gnt_o` at a rising edge. At that edge the block latches `we_i` and the range check and performs the access.
- In range: `BASE_ADDR <= addr_i < BASE_ADDR + 4*WORD_COUNT`. Word index = `addr_i[$clog2(WORD_COUNT)+1:2]`.
- Write in range: update only the byte lanes with `be_i` set. `be_i`=0 leaves the RAM unchanged but still produces a response. `rdata_o` = 0 in the response.
- Read in range: the RAM word is captured into the response register at the acceptance edge.
- Out of range: no RAM update. `rdata_o` = 32'hDEAD_BEEF and `err_o` = 1 in the response. Writes also respond with `err_o` = 1.
- Every accepted transaction, read or write, receives exactly one `rvalid_o` pulse.
- State machine:
  - IDLE: if `req_i` and `GNT_DELAY`=0, grant now and go to LAT (or to RESP if `RVALID_DELAY`=1). If `req_i` and `GNT_DELAY`>0, go to WAIT_GNT with the counter at 1.
  - WAIT_GNT: count cycles with `req_i` high. When count = `GNT_DELAY`, set `gnt_o`=1 and accept. If `req_i` drops, return to IDLE and clear the counter; no acceptance occurs.
  - LAT: count `RVALID_DELAY`-1 cycles, then go to RESP.
  - RESP: `rvalid_o`=1 for this cycle. If `req_i` is high here, treat it as in IDLE: with `GNT_DELAY`=0 it is granted in this same cycle (back-to-back). Otherwise go to IDLE.
- `gnt_o` is never asserted in LAT or while the counter is below its target.
- RAM contents are not reset. The read-after-write order is guaranteed by the single-outstanding-transaction rule.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, state IDLE, counters 0.
- Latency: `req_i` rises in cycle c. `gnt_o` is high in cycle c+`GNT_DELAY`. `rvalid_o` is high in cycle c+`GNT_DELAY`+`RVALID_DELAY`.
- Throughput with `GNT_DELAY`=0 and `RVALID_DELAY`=1: one transaction per cycle. With larger delays: one transaction per `GNT_DELAY`+`RVALID_DELAY` cycles.
- Signal validity: `rdata_o` and `err_o` hold their value outside the `rvalid_o` cycle until the next response; consumers ignore them.
- Reset asserted mid-transaction: the pending response is discarded and no `rvalid_o` appears. A write already accepted remains in the RAM.
- Address range boundaries: `BASE_ADDR-4` and `BASE_ADDR+4*WORD_COUNT` are out of range; the first and last words are in range.

## Configuration
- Macro `MEM_RESP_RANDOM_STALL_EN`.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - At each entry into WAIT_GNT or IDLE acceptance evaluation, the extra stall `lfsr[1:0]` is sampled. The effective grant delay becomes `GNT_DELAY` + `lfsr[1:0]`.
  - A nonzero extra stall forces the WAIT_GNT path even when `GNT_DELAY`=0.
- Undefined: no LFSR logic; grant delay is exactly `GNT_DELAY`.

## Test plan
- Defaults. Write 32'hCAFE_F00D with `be_i`=4'hF to 32'h0010_0010, then read the same address. Required: grant same cycle each time; `rvalid_o` one cycle later; the read returns 32'hCAFE_F00D with `err_o`=0.
- Partial write. Start from word 32'h1111_1111 and write 32'hAABB_CCDD with `be_i`=4'b0101. A read must return 32'h11BB_11DD.
- Delays. Set `GNT_DELAY`=3 and `RVALID_DELAY`=2, and issue a 4-word line-fill read burst with `req_i` held. Required: each `gnt_o` arrives 3 cycles after `req_i`, and each `rvalid_o` 2 cycles after its grant. All four words are returned in order.
- Out of range. Read and write at 32'h0000_0000 and 32'h0010_1000 (`WORD_COUNT`=1024). Required: each receives one response with `err_o`=1; reads return 32'hDEAD_BEEF; the RAM is unchanged.
- Reset abort. Set `RVALID_DELAY`=4, accept a read, and pulse `reset` 2 cycles later. Required: no `rvalid_o` follows; all outputs are 0 during reset; the next request is served normally.
- Back-to-back. With defaults, hold `req_i` for 4 consecutive cycles at incrementing addresses. Required: 4 consecutive `gnt_o` cycles followed by 4 consecutive `rvalid_o` cycles, with data matching each address.
